// File: rtl/sl_axi_obi_pkg.sv
// rtl/sl_axi_obi_pkg.sv - shared types and constants for the AXI-to-OBI responder
package sl_axi_obi_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_ID_W   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
    } state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [5:0]            atop;
    } sl_axi_aw_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } sl_axi_ar_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
    } sl_axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } sl_axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } sl_axi_r_t;

    typedef struct packed {
        sl_axi_aw_t aw;
        logic       aw_valid;
        sl_axi_w_t  w;
        logic       w_valid;
        logic       b_ready;
        sl_axi_ar_t ar;
        logic       ar_valid;
        logic       r_ready;
    } sl_axi_req_t;

    typedef struct packed {
        logic      aw_ready;
        logic      w_ready;
        sl_axi_b_t b;
        logic      b_valid;
        logic      ar_ready;
        sl_axi_r_t r;
        logic      r_valid;
    } sl_axi_rsp_t;

    typedef struct packed {
        logic                    req;
        logic                    we;
        logic [AXI_DATA_W/8-1:0] be;
        logic [AXI_ADDR_W-1:0]   addr;
        logic [AXI_DATA_W-1:0]   wdata;
    } sl_obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [AXI_DATA_W-1:0] rdata;
    } sl_obi_rsp_t;

endpackage

// File: rtl/sl_axi_obi_responder.sv
// rtl/sl_axi_obi_responder.sv - AXI4 subordinate re-issuing each beat as one OBI transaction
module sl_axi_obi_responder
    import sl_axi_obi_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 4,
    parameter type axi_req_t  = sl_axi_obi_pkg::sl_axi_req_t,
    parameter type axi_rsp_t  = sl_axi_obi_pkg::sl_axi_rsp_t,
    parameter type obi_req_t  = sl_axi_obi_pkg::sl_obi_req_t,
    parameter type obi_resp_t = sl_axi_obi_pkg::sl_obi_rsp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  axi_req_i,
    output axi_rsp_t  axi_rsp_o,
    output obi_req_t  obi_req_o,
    input  obi_resp_t obi_rsp_i
);

    if (DataWidth != 32) begin : gen_dw_check
        $error("sl_axi_obi_responder supports DataWidth=32 only");
    end

    state_e                   state_q, state_d;
    logic [IdWidth-1:0]       id_q, id_d;
    logic [AddrWidth-1:0]     addr_q, addr_d, addr_next;
    logic [7:0]               len_q, len_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [1:0]               burst_q, burst_d;
    logic                     err_q, err_d;
    logic                     last_mismatch_q, last_mismatch_d;
    logic                     rr_last_write_q, rr_last_write_d;  // set: write wins the next tie
    logic [DataWidth-1:0]     rdata_q, rdata_d;
    logic [DataWidth-1:0]     wdata_q, wdata_d;
    logic [DataWidth/8-1:0]   strb_q, strb_d;
    logic                     pick_wr;
    logic                     is_last;

    // State and transaction registers; reset drops any burst in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            id_q            <= '0;
            addr_q          <= '0;
            len_q           <= '0;
            cnt_q           <= '0;
            burst_q         <= '0;
            err_q           <= 1'b0;
            last_mismatch_q <= 1'b0;
            rr_last_write_q <= 1'b1;
            rdata_q         <= '0;
            wdata_q         <= '0;
            strb_q          <= '0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            cnt_q           <= cnt_d;
            burst_q         <= burst_d;
            err_q           <= err_d;
            last_mismatch_q <= last_mismatch_d;
            rr_last_write_q <= rr_last_write_d;
            rdata_q         <= rdata_d;
            wdata_q         <= wdata_d;
            strb_q          <= strb_d;
        end
    end

    // Arbitration, beat sequencing and all AXI/OBI outputs
    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        addr_d          = addr_q;
        len_d           = len_q;
        cnt_d           = cnt_q;
        burst_d         = burst_q;
        err_d           = err_q;
        last_mismatch_d = last_mismatch_q;
        rr_last_write_d = rr_last_write_q;
        rdata_d         = rdata_q;
        wdata_d         = wdata_q;
        strb_d          = strb_q;
        axi_rsp_o       = '0;
        obi_req_o       = '0;
        pick_wr         = axi_req_i.aw_valid & (~axi_req_i.ar_valid | rr_last_write_q);
        is_last         = (cnt_q == len_q);
        addr_next       = (burst_q == BURST_INCR) ? addr_q + AddrWidth'(4) : addr_q;

        case (state_q)
            IDLE: begin
                if (pick_wr) begin
                    axi_rsp_o.aw_ready = 1'b1;
                    id_d            = axi_req_i.aw.id;
                    addr_d          = axi_req_i.aw.addr;
                    len_d           = axi_req_i.aw.len;
                    burst_d         = axi_req_i.aw.burst;
                    err_d           = (axi_req_i.aw.size != 3'd2)
                                    | ((axi_req_i.aw.burst != BURST_FIXED) && (axi_req_i.aw.burst != BURST_INCR))
                                    | (axi_req_i.aw.atop != '0);
                    cnt_d           = '0;
                    last_mismatch_d = 1'b0;
                    rr_last_write_d = 1'b0;
                    state_d         = WR_DATA;
                end else if (axi_req_i.ar_valid) begin
                    axi_rsp_o.ar_ready = 1'b1;
                    id_d            = axi_req_i.ar.id;
                    addr_d          = axi_req_i.ar.addr;
                    len_d           = axi_req_i.ar.len;
                    burst_d         = axi_req_i.ar.burst;
                    err_d           = (axi_req_i.ar.size != 3'd2)
                                    | ((axi_req_i.ar.burst != BURST_FIXED) && (axi_req_i.ar.burst != BURST_INCR));
                    cnt_d           = '0;
                    rdata_d         = '0;
                    rr_last_write_d = 1'b1;
                    state_d         = err_d ? RD_RESP : RD_REQ;
                end
            end
            RD_REQ: begin
                obi_req_o.req  = 1'b1;
                obi_req_o.be   = '1;
                obi_req_o.addr = {addr_q[AddrWidth-1:2], 2'b00};
                if (obi_rsp_i.gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (obi_rsp_i.rvalid) begin
                    rdata_d = obi_rsp_i.rdata;
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                axi_rsp_o.r_valid = 1'b1;
                axi_rsp_o.r.id    = id_q;
                axi_rsp_o.r.data  = rdata_q;
                axi_rsp_o.r.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
                axi_rsp_o.r.last  = is_last;
                if (axi_req_i.r_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = addr_next;
                        state_d = err_q ? RD_RESP : RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                axi_rsp_o.w_ready = 1'b1;
                if (axi_req_i.w_valid) begin
                    wdata_d         = axi_req_i.w.data;
                    strb_d          = axi_req_i.w.strb;
                    last_mismatch_d = last_mismatch_q | (axi_req_i.w.last != is_last);
                    if (!err_q && (axi_req_i.w.strb != '0)) begin
                        state_d = WR_REQ;
                    end else if (is_last) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = addr_next;
                    end
                end
            end
            WR_REQ: begin
                obi_req_o.req   = 1'b1;
                obi_req_o.we    = 1'b1;
                obi_req_o.be    = strb_q;
                obi_req_o.addr  = {addr_q[AddrWidth-1:2], 2'b00};
                obi_req_o.wdata = wdata_q;
                if (obi_rsp_i.gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (obi_rsp_i.rvalid) begin
                    if (is_last) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = addr_next;
                        state_d = WR_DATA;
                    end
                end
            end
            WR_RESP: begin
                axi_rsp_o.b_valid = 1'b1;
                axi_rsp_o.b.id    = id_q;
                axi_rsp_o.b.resp  = (err_q | last_mismatch_q) ? RESP_SLVERR : RESP_OKAY;
                if (axi_req_i.b_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // An OBI response is only legal while a transaction is outstanding
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        obi_rsp_i.rvalid |-> (state_q == RD_WAIT || state_q == WR_WAIT));

endmodule

// File: tb/tb_sl_axi_obi_responder.sv
// tb/tb_sl_axi_obi_responder.sv - directed vector bench for sl_axi_obi_responder
module tb_sl_axi_obi_responder;
    import sl_axi_obi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    sl_axi_req_t areq;
    sl_axi_rsp_t arsp;
    sl_obi_req_t oreq;
    sl_obi_rsp_t orsp;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    sl_axi_obi_responder dut (
        .clk_i(clk), .rst_ni(rst_n),
        .axi_req_i(areq), .axi_rsp_o(arsp),
        .obi_req_o(oreq), .obi_rsp_i(orsp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h1000_0004) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
    endfunction

    // OBI subordinate model: grant after gnt_dly waiting cycles, rvalid rv_dly cycles after gnt
    int          gnt_dly = 0, rv_dly = 0, wcnt = 0, rv_cnt = -1;
    int          stab_err = 0, ovl_err = 0;
    logic        prev_wait = 1'b0;
    sl_obi_req_t prev_req;
    logic [31:0] pend_addr;
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [3:0]  log_be[$];
    logic [31:0] log_wdata[$];

    initial begin
        orsp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                orsp = '0; rv_cnt = -1; wcnt = 0; prev_wait = 1'b0;
                continue;
            end
            orsp.rvalid = 1'b0;
            orsp.rdata  = '0;
            if (rv_cnt == 0) begin
                orsp.rvalid = 1'b1;
                orsp.rdata  = mem_rd(pend_addr);
                rv_cnt = -1;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
            end
            if (oreq.req && (rv_cnt >= 0 || orsp.rvalid)) ovl_err++;
            if (prev_wait && (!oreq.req || oreq !== prev_req)) stab_err++;
            orsp.gnt  = 1'b0;
            prev_wait = 1'b0;
            if (oreq.req) begin
                if (wcnt >= gnt_dly) begin
                    orsp.gnt = 1'b1;
                    wcnt = 0;
                    log_addr.push_back(oreq.addr);
                    log_we.push_back(oreq.we);
                    log_be.push_back(oreq.be);
                    log_wdata.push_back(oreq.wdata);
                    pend_addr = oreq.addr;
                    rv_cnt = rv_dly;
                end else begin
                    wcnt++;
                    prev_wait = 1'b1;
                    prev_req = oreq;
                end
            end
        end
    end

    logic [31:0] rb_data[$];
    logic [1:0]  rb_resp[$];
    logic        rb_last[$];
    logic [3:0]  rb_id[$];
    int          lat;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        rb_data.delete(); rb_resp.delete(); rb_last.delete(); rb_id.delete();
        @(negedge clk);
        areq.ar.id = id; areq.ar.addr = addr; areq.ar.len = len;
        areq.ar.size = size; areq.ar.burst = burst; areq.ar_valid = 1'b1;
        #1;
        n = 0;
        while (!arsp.ar_ready && n < 200) begin @(negedge clk); #1; n++; end
        chk("ar_accept", arsp.ar_ready, 1);
        @(posedge clk);
        @(negedge clk);
        areq.ar_valid = 1'b0; areq.r_ready = 1'b1;
        lat = 1; n = 0;
        while (rb_data.size() < int'(len) + 1 && n < 2000) begin
            if (arsp.r_valid) begin
                rb_data.push_back(arsp.r.data); rb_resp.push_back(arsp.r.resp);
                rb_last.push_back(arsp.r.last); rb_id.push_back(arsp.r.id);
            end else if (rb_data.size() == 0) begin
                lat++;
            end
            @(negedge clk);
            n++;
        end
        areq.r_ready = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop,
                            input logic [7:0] lmask, input logic [7:0] zmask);
        int n;
        @(negedge clk);
        areq.aw.id = id; areq.aw.addr = addr; areq.aw.len = len; areq.aw.size = size;
        areq.aw.burst = burst; areq.aw.atop = atop; areq.aw_valid = 1'b1;
        #1;
        n = 0;
        while (!arsp.aw_ready && n < 200) begin @(negedge clk); #1; n++; end
        chk("aw_accept", arsp.aw_ready, 1);
        @(posedge clk);
        for (int k = 0; k <= int'(len); k++) begin
            @(negedge clk);
            areq.aw_valid = 1'b0;
            areq.w.data = 32'(32'h11 * (k + 1));
            areq.w.strb = zmask[k] ? 4'h0 : 4'hF;
            areq.w.last = lmask[k];
            areq.w_valid = 1'b1;
            #1;
            n = 0;
            while (!arsp.w_ready && n < 200) begin @(negedge clk); #1; n++; end
            chk("w_accept", arsp.w_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        areq.w_valid = 1'b0; areq.b_ready = 1'b1;
        n = 0;
        while (!arsp.b_valid && n < 200) begin @(negedge clk); n++; end
        chk("b_seen", arsp.b_valid, 1);
        b_id = arsp.b.id; b_resp = arsp.b.resp;
        @(posedge clk);
        @(negedge clk);
        areq.b_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  atop;
        int          gdly;
        int          n_obi;
        logic [31:0] a [4];
        logic [1:0]  resp;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                                input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                                input logic [5:0] atop, input int gdly, input int n_obi,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                                input logic [31:0] a3, input logic [1:0] resp);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.atop = atop; v.gdly = gdly; v.n_obi = n_obi;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3; v.resp = resp;
        return v;
    endfunction

    localparam int NV = 9;
    vec_t        tv [NV];
    logic        gorder[$];
    int          n0, naw, seen;
    logic        took_aw, took_ar;
    logic [31:0] exp_d;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = mk(0, 4'h3, 32'h1000_0006, 8'd0, 3'd2, BURST_INCR,  6'h0,  0, 1, 32'h1000_0004, 0, 0, 0, RESP_OKAY);
        tv[1] = mk(0, 4'h5, 32'hFFFF_FFF8, 8'd2, 3'd2, BURST_INCR,  6'h0,  1, 3, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 0, RESP_OKAY);
        tv[2] = mk(0, 4'h1, 32'h0000_0040, 8'd2, 3'd2, BURST_FIXED, 6'h0,  0, 3, 32'h40, 32'h40, 32'h40, 0, RESP_OKAY);
        tv[3] = mk(0, 4'h2, 32'h0000_0080, 8'd0, 3'd1, BURST_INCR,  6'h0,  0, 0, 0, 0, 0, 0, RESP_SLVERR);
        tv[4] = mk(0, 4'h4, 32'h0000_0100, 8'd1, 3'd2, 2'b10,       6'h0,  0, 0, 0, 0, 0, 0, RESP_SLVERR);
        tv[5] = mk(1, 4'h6, 32'h0000_2000, 8'd3, 3'd2, BURST_INCR,  6'h0,  2, 4, 32'h2000, 32'h2004, 32'h2008, 32'h200C, RESP_OKAY);
        tv[6] = mk(1, 4'h7, 32'h0000_3002, 8'd1, 3'd2, BURST_FIXED, 6'h0,  0, 2, 32'h3000, 32'h3000, 0, 0, RESP_OKAY);
        tv[7] = mk(1, 4'h8, 32'h0000_0500, 8'd0, 3'd2, BURST_INCR,  6'h20, 0, 0, 0, 0, 0, 0, RESP_SLVERR);
        tv[8] = mk(1, 4'h9, 32'h0000_0600, 8'd0, 3'd0, BURST_INCR,  6'h0,  0, 0, 0, 0, 0, 0, RESP_SLVERR);

        areq = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_axi_rsp_zero", arsp == '0, 1);
        chk("rst_obi_req_zero", oreq == '0, 1);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_axi_rsp_zero", arsp == '0, 1);
        chk("idle_obi_req_zero", oreq == '0, 1);

        // Contested AR/AW right after reset: write first, then read, then the second write
        n0 = log_addr.size(); naw = 0; gnt_dly = 0; rv_dly = 0;
        @(negedge clk);
        areq.ar.id = 4'h2; areq.ar.addr = 32'h3000; areq.ar.len = 8'd0; areq.ar.size = 3'd2;
        areq.ar.burst = BURST_INCR; areq.ar_valid = 1'b1;
        areq.aw.id = 4'h1; areq.aw.addr = 32'h4000; areq.aw.len = 8'd0; areq.aw.size = 3'd2;
        areq.aw.burst = BURST_INCR; areq.aw.atop = 6'h0; areq.aw_valid = 1'b1;
        areq.w.data = 32'h77; areq.w.strb = 4'hF; areq.w.last = 1'b1; areq.w_valid = 1'b1;
        areq.b_ready = 1'b1; areq.r_ready = 1'b1;
        #1;
        chk("tie_aw_ready", arsp.aw_ready, 1);
        chk("tie_ar_ready", arsp.ar_ready, 0);
        took_aw = 1'b0; took_ar = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (took_aw) begin
                    if (naw == 1) areq.aw.addr = 32'h5000;
                    else areq.aw_valid = 1'b0;
                end
                if (took_ar) areq.ar_valid = 1'b0;
                #1;
            end
            took_aw = arsp.aw_ready; took_ar = arsp.ar_ready;
            if (took_aw) begin gorder.push_back(1'b1); naw++; end
            if (took_ar) gorder.push_back(1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        areq.w_valid = 1'b0; areq.b_ready = 1'b0; areq.r_ready = 1'b0;
        chk("tie_grants", gorder.size(), 3);
        if (gorder.size() == 3) begin
            chk("tie_grant0_write", gorder[0], 1);
            chk("tie_grant1_read",  gorder[1], 0);
            chk("tie_grant2_write", gorder[2], 1);
        end
        chk("tie_nobi", log_addr.size() - n0, 3);
        if (log_addr.size() - n0 == 3) begin
            chk("tie_obi0_addr", log_addr[n0], 32'h4000);
            chk("tie_obi1_addr", log_addr[n0 + 1], 32'h3000);
            chk("tie_obi1_we",   log_we[n0 + 1], 0);
            chk("tie_obi2_addr", log_addr[n0 + 2], 32'h5000);
        end

        // Vector table
        for (int i = 0; i < NV; i++) begin
            gnt_dly = tv[i].gdly; rv_dly = 0;
            n0 = log_addr.size();
            if (tv[i].wr)
                do_write(tv[i].id, tv[i].addr, tv[i].len, tv[i].size, tv[i].burst, tv[i].atop,
                         8'(1 << tv[i].len), 8'h00);
            else
                do_read(tv[i].id, tv[i].addr, tv[i].len, tv[i].size, tv[i].burst);
            chk($sformatf("v%0d_nobi", i), log_addr.size() - n0, tv[i].n_obi);
            for (int k = 0; k < tv[i].n_obi && n0 + k < log_addr.size(); k++) begin
                chk($sformatf("v%0d_obi%0d_addr", i, k), log_addr[n0 + k], tv[i].a[k]);
                chk($sformatf("v%0d_obi%0d_we", i, k), log_we[n0 + k], tv[i].wr);
                chk($sformatf("v%0d_obi%0d_be", i, k), log_be[n0 + k], 4'hF);
                if (tv[i].wr) chk($sformatf("v%0d_obi%0d_wdata", i, k), log_wdata[n0 + k], 32'(32'h11 * (k + 1)));
            end
            if (tv[i].wr) begin
                chk($sformatf("v%0d_b_resp", i), b_resp, tv[i].resp);
                chk($sformatf("v%0d_b_id", i), b_id, tv[i].id);
            end else begin
                chk($sformatf("v%0d_r_beats", i), rb_data.size(), int'(tv[i].len) + 1);
                for (int k = 0; k < rb_data.size(); k++) begin
                    exp_d = (tv[i].resp == RESP_OKAY) ? mem_rd(tv[i].a[k]) : 32'h0;
                    chk($sformatf("v%0d_r%0d_data", i, k), rb_data[k], exp_d);
                    chk($sformatf("v%0d_r%0d_resp", i, k), rb_resp[k], tv[i].resp);
                    chk($sformatf("v%0d_r%0d_last", i, k), rb_last[k], (k == int'(tv[i].len)));
                    chk($sformatf("v%0d_r%0d_id", i, k), rb_id[k], tv[i].id);
                end
            end
            if (i == 0) chk("v0_latency", lat, 3);
        end
        chk("obi_hold_stable", stab_err, 0);

        // Early W.last on beat 0 and a zero-strobe second beat
        gnt_dly = 0; n0 = log_addr.size();
        do_write(4'hA, 32'h700, 8'd1, 3'd2, BURST_INCR, 6'h0, 8'h03, 8'h02);
        chk("ws_nobi", log_addr.size() - n0, 1);
        if (log_addr.size() > n0) begin
            chk("ws_obi_addr",  log_addr[n0], 32'h700);
            chk("ws_obi_wdata", log_wdata[n0], 32'h11);
        end
        chk("ws_b_resp", b_resp, RESP_SLVERR);
        chk("ws_b_id", b_id, 4'hA);

        // Reset in the middle of a FIXED read: once while requesting, once while waiting
        for (int rc = 0; rc < 2; rc++) begin
            gnt_dly = (rc == 0) ? 6 : 0;
            rv_dly  = (rc == 0) ? 0 : 6;
            @(negedge clk);
            areq.ar.id = 4'hC; areq.ar.addr = 32'h6000; areq.ar.len = 8'd3; areq.ar.size = 3'd2;
            areq.ar.burst = BURST_FIXED; areq.ar_valid = 1'b1;
            #1;
            chk($sformatf("rst%0d_ar_ready", rc), arsp.ar_ready, 1);
            @(posedge clk);
            @(negedge clk);
            areq.ar_valid = 1'b0; areq.r_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("rst%0d_pre_req", rc), oreq.req, (rc == 0));
            #2;
            rst_n = 1'b0;
            #1;
            chk($sformatf("rst%0d_req_drop", rc), oreq.req, 0);
            chk($sformatf("rst%0d_rvalid_drop", rc), arsp.r_valid, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (oreq.req || arsp.r_valid) seen++;
            end
            chk($sformatf("rst%0d_quiet", rc), seen, 0);
            areq.r_ready = 1'b0;
        end
        gnt_dly = 0; rv_dly = 0; n0 = log_addr.size();
        do_read(4'hD, 32'h7008, 8'd0, 3'd2, BURST_INCR);
        chk("post_rst_nobi", log_addr.size() - n0, 1);
        chk("post_rst_beats", rb_data.size(), 1);
        if (rb_data.size() == 1) begin
            chk("post_rst_data", rb_data[0], 32'h7008 ^ 32'hA5A5_5A5A);
            chk("post_rst_resp", rb_resp[0], RESP_OKAY);
        end
        chk("obi_no_overlap", ovl_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
